scan_chain_ctrl: RTL and testbench

Scan test controller that drives the scan port (`scan_en`, `scan_in`) of a downstream scan-enabled register chain and consumes its `scan_out`. It accepts parallel test vectors with their expected responses through a valid/ready handshake. Each vector is shifted serially into the chain, followed by a programmable number of functional capture clocks. The captured state is then unloaded and compared against the expected response. Unloading a vector overlaps with loading the next one.

---
 rtl/scan_chain_ctrl_if.sv | 29 ++
 rtl/scan_chain_ctrl.sv | 146 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_if.sv
// Scan controller bundle: vector handshake, scan port and response outputs.
interface scan_chain_ctrl_if #(
    parameter int unsigned CHAIN_LEN = 2
) ();
    logic                 vec_valid;
    logic                 vec_ready;
    logic [CHAIN_LEN-1:0] vec_in;
    logic [CHAIN_LEN-1:0] exp_in;
    logic                 scan_en;
    logic                 scan_in;
    logic                 scan_out;
    logic                 resp_valid;
    logic [CHAIN_LEN-1:0] resp_data;
    logic                 mismatch;
    logic [7:0]           fail_count;
    logic                 busy;

    // Controller side.
    modport master (
        input  vec_valid, vec_in, exp_in, scan_out,
        output vec_ready, scan_en, scan_in, resp_valid, resp_data, mismatch, fail_count, busy
    );

    // Vector source / chain side.
    modport slave (
        output vec_valid, vec_in, exp_in, scan_out,
        input  vec_ready, scan_en, scan_in, resp_valid, resp_data, mismatch, fail_count, busy
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan test controller: loads vectors serially, runs capture clocks, unloads and
// compares the captured response while the next vector is being loaded.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN      = 2,
    parameter int unsigned CAPTURE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    scan_chain_ctrl_if.master  ctrl_io
);
    localparam int unsigned CntMax = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);

    typedef enum logic [1:0] {StIdle, StShift, StCapture, StFlush} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] load_sr_q, exp_q, cmp_q, resp_sr_q;
    logic                 resp_pending_q, scan_en_q, resp_valid_q, mismatch_q;
    logic [7:0]           fail_count_q;

    logic                 vec_ready, hs, shift_last, cap_last;
    logic                 capture_done, unload_en, unload_last, resp_diff;
    logic [CHAIN_LEN-1:0] resp_next;

    assign shift_last   = (cnt_q == CntW'(CHAIN_LEN - 1));
    assign cap_last     = (cnt_q == CntW'(CAPTURE_CYCLES - 1));
    assign hs           = ctrl_io.vec_valid & vec_ready;
    assign capture_done = (state_q == StCapture) & cap_last;
    // SHIFT and FLUSH both last CHAIN_LEN cycles, so the phase counter marks the last unload bit.
    assign unload_en    = ((state_q == StShift) | (state_q == StFlush)) & resp_pending_q;
    assign unload_last  = unload_en & shift_last;
    assign resp_next    = {resp_sr_q[CHAIN_LEN-2:0], ctrl_io.scan_out};
    assign resp_diff    = (resp_next != cmp_q);

    // State register and phase cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter restarts at every phase change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (hs) state_d = StShift;
            end
            StShift: begin
                if (shift_last) begin
                    state_d = StCapture;
                    cnt_d   = '0;
                end
            end
            StCapture: begin
                if (cap_last) begin
                    state_d = hs ? StShift : StFlush;
                    cnt_d   = '0;
                end
            end
            StFlush: begin
                if (shift_last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake-side outputs decoded from the current state.
    always_comb begin
        vec_ready = 1'b0;
        unique case (state_q)
            StIdle:    vec_ready = 1'b1;
            StCapture: vec_ready = cap_last;
            default:   vec_ready = 1'b0;
        endcase
    end

    // Scan enable registered from the next state so the chain sees a clean flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_en_q <= 1'b0;
        end else begin
            scan_en_q <= (state_d == StShift) | (state_d == StFlush);
        end
    end

    // Load path: stimulus shifts out MSB first and leaves zeros behind, so FLUSH drives 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_sr_q <= '0;
            exp_q     <= '0;
            cmp_q     <= '0;
        end else begin
            if (hs) begin
                load_sr_q <= ctrl_io.vec_in;
                exp_q     <= ctrl_io.exp_in;
            end else if (state_q == StShift) begin
                load_sr_q <= {load_sr_q[CHAIN_LEN-2:0], 1'b0};
            end
            // Snapshot the expectation of the vector just captured before exp_q is overwritten.
            if (capture_done) cmp_q <= exp_q;
        end
    end

    // Unload path, compare and saturating mismatch counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_pending_q <= 1'b0;
            resp_sr_q      <= '0;
            resp_valid_q   <= 1'b0;
            mismatch_q     <= 1'b0;
            fail_count_q   <= '0;
        end else begin
            if (capture_done)     resp_pending_q <= 1'b1;
            else if (unload_last) resp_pending_q <= 1'b0;
            if (unload_en) resp_sr_q <= resp_next;
            resp_valid_q <= unload_last;
            if (unload_last) begin
                mismatch_q <= resp_diff;
                if (resp_diff && fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
            end
        end
    end

    assign ctrl_io.vec_ready  = vec_ready;
    assign ctrl_io.busy       = (state_q != StIdle);
    assign ctrl_io.scan_en    = scan_en_q;
    assign ctrl_io.scan_in    = load_sr_q[CHAIN_LEN-1];
    assign ctrl_io.resp_valid = resp_valid_q;
    assign ctrl_io.resp_data  = resp_sr_q;
    assign ctrl_io.mismatch   = mismatch_q;
    assign ctrl_io.fail_count = fail_count_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: two controllers (1 and 2 capture cycles) each driving a 2-bit scan
// chain whose functional behaviour is a small FSM: 00->01->11->00, 10->00.
module tb_scan_chain_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_chain_ctrl_if #(.CHAIN_LEN(2)) bus_a ();
    scan_chain_ctrl_if #(.CHAIN_LEN(2)) bus_b ();

    scan_chain_ctrl #(.CHAIN_LEN(2), .CAPTURE_CYCLES(1)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus_a.master)
    );
    scan_chain_ctrl #(.CHAIN_LEN(2), .CAPTURE_CYCLES(2)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus_b.master)
    );

    // Downstream scan chains: shift toward the MSB when enabled, else one functional step.
    function automatic logic [1:0] func_next(input logic [1:0] cur);
        case (cur)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    logic [1:0] chain_a = 2'b00;
    logic [1:0] chain_b = 2'b00;
    always @(posedge clk) begin
        chain_a <= bus_a.scan_en ? {chain_a[0], bus_a.scan_in} : func_next(chain_a);
        chain_b <= bus_b.scan_en ? {chain_b[0], bus_b.scan_in} : func_next(chain_b);
    end
    assign bus_a.scan_out = chain_a[1];
    assign bus_b.scan_out = chain_b[1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [1:0] data;
        logic       mm;
    } resp_t;
    typedef struct {
        logic [1:0] vec;
        logic [1:0] exp;
        logic [1:0] resp;
        logic       mm;
    } vec_rec_t;
    typedef struct {
        logic scan_en;
        logic vec_ready;
        logic busy;
        logic resp_valid;
    } trace_t;

    resp_t    exp_a[$];
    resp_t    exp_b[$];
    vec_rec_t feed_q[$];
    int       resp_cyc[$];
    resp_t    ra, rb;

    // Response scoreboards: every resp_valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (bus_a.resp_valid) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_resp_valid", 32'(bus_a.resp_valid), 32'd0);
            end else begin
                ra = exp_a.pop_front();
                check("a_resp_data", 32'(bus_a.resp_data), 32'(ra.data));
                check("a_mismatch", 32'(bus_a.mismatch), 32'(ra.mm));
                resp_cyc.push_back(cyc);
            end
        end
    end
    always @(negedge clk) begin
        if (bus_b.resp_valid) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_resp_valid", 32'(bus_b.resp_valid), 32'd0);
            end else begin
                rb = exp_b.pop_front();
                check("b_resp_data", 32'(bus_b.resp_data), 32'(rb.data));
                check("b_mismatch", 32'(bus_b.mismatch), 32'(rb.mm));
            end
        end
    end

    // Offers queued vectors to DUT A with vec_valid held high; call just after a rising edge.
    task automatic feed_a();
        vec_rec_t v;
        bit       ok;
        bus_a.vec_valid = 1'b1;
        while (feed_q.size() > 0) begin
            v = feed_q.pop_front();
            bus_a.vec_in = v.vec;
            bus_a.exp_in = v.exp;
            exp_a.push_back('{data: v.resp, mm: v.mm});
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus_a.vec_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check("a_handshake_timeout", 32'd0, 32'd1);
                feed_q.delete();
                break;
            end
            @(posedge clk);
            #1;
        end
        bus_a.vec_valid = 1'b0;
    endtask

    // Waits for DUT A to drain all expected responses and return to IDLE.
    task automatic drain_a();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus_a.busy && exp_a.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("a_drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    vec_rec_t b2b[4];
    trace_t   tr_a[6];
    trace_t   tr_b[7];

    initial begin
        b2b[0] = '{vec: 2'b00, exp: 2'b01, resp: 2'b01, mm: 1'b0};
        b2b[1] = '{vec: 2'b01, exp: 2'b11, resp: 2'b11, mm: 1'b0};
        b2b[2] = '{vec: 2'b11, exp: 2'b00, resp: 2'b00, mm: 1'b0};
        b2b[3] = '{vec: 2'b10, exp: 2'b00, resp: 2'b00, mm: 1'b0};
        // Cycles 1..6 after the handshake edge: SHIFT, SHIFT, CAPTURE, FLUSH, FLUSH, IDLE.
        tr_a[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_a[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_a[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tr_a[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_a[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_a[5] = '{1'b0, 1'b1, 1'b0, 1'b1};
        // Two capture cycles stretch the sequence by one.
        tr_b[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_b[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_b[2] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tr_b[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tr_b[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_b[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tr_b[6] = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        bus_a.vec_valid = 1'b0;
        bus_a.vec_in    = 2'b00;
        bus_a.exp_in    = 2'b00;
        bus_b.vec_valid = 1'b0;
        bus_b.vec_in    = 2'b00;
        bus_b.exp_in    = 2'b00;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_scan_en", 32'(bus_a.scan_en), 32'd0);
        check("rst_scan_in", 32'(bus_a.scan_in), 32'd0);
        check("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
        check("rst_resp_data", 32'(bus_a.resp_data), 32'd0);
        check("rst_mismatch", 32'(bus_a.mismatch), 32'd0);
        check("rst_fail_count", 32'(bus_a.fail_count), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_vec_ready", 32'(bus_a.vec_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single vector 00, expected 01: cycle-by-cycle trace.
        bus_a.vec_valid = 1'b1;
        bus_a.vec_in    = 2'b00;
        bus_a.exp_in    = 2'b01;
        exp_a.push_back('{data: 2'b01, mm: 1'b0});
        @(posedge clk);
        #1;
        bus_a.vec_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("single_scan_en_c%0d", i + 1), 32'(bus_a.scan_en), 32'(tr_a[i].scan_en));
            check($sformatf("single_vec_ready_c%0d", i + 1), 32'(bus_a.vec_ready),
                  32'(tr_a[i].vec_ready));
            check($sformatf("single_busy_c%0d", i + 1), 32'(bus_a.busy), 32'(tr_a[i].busy));
            check($sformatf("single_resp_valid_c%0d", i + 1), 32'(bus_a.resp_valid),
                  32'(tr_a[i].resp_valid));
        end
        drain_a();

        // Back-to-back vectors from the table; responses three cycles apart.
        resp_cyc.delete();
        for (int i = 0; i < 4; i++) feed_q.push_back(b2b[i]);
        feed_a();
        drain_a();
        check("b2b_resp_count", 32'(resp_cyc.size()), 32'd4);
        for (int i = 1; i < resp_cyc.size(); i++) begin
            check($sformatf("b2b_spacing_%0d", i), 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd3);
        end
        check("b2b_fail_count", 32'(bus_a.fail_count), 32'd0);

        // Wrong expectation: vector 01 captures 11, expected 00.
        feed_q.push_back('{vec: 2'b01, exp: 2'b00, resp: 2'b11, mm: 1'b1});
        feed_a();
        drain_a();
        check("mm_fail_count", 32'(bus_a.fail_count), 32'd1);

        // Reset during the second SHIFT cycle: vector is dropped, fail_count cleared.
        bus_a.vec_valid = 1'b1;
        bus_a.vec_in    = 2'b01;
        bus_a.exp_in    = 2'b11;
        @(posedge clk);
        #1;
        bus_a.vec_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_scan_en", 32'(bus_a.scan_en), 32'd0);
        check("rstmid_busy", 32'(bus_a.busy), 32'd0);
        check("rstmid_vec_ready", 32'(bus_a.vec_ready), 32'd1);
        check("rstmid_fail_count", 32'(bus_a.fail_count), 32'd0);
        check("rstmid_resp_data", 32'(bus_a.resp_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Two capture cycles on DUT B: vector 00 -> 01 -> 11.
        bus_b.vec_valid = 1'b1;
        bus_b.vec_in    = 2'b00;
        bus_b.exp_in    = 2'b11;
        exp_b.push_back('{data: 2'b11, mm: 1'b0});
        @(posedge clk);
        #1;
        bus_b.vec_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("cap2_scan_en_c%0d", i + 1), 32'(bus_b.scan_en), 32'(tr_b[i].scan_en));
            check($sformatf("cap2_vec_ready_c%0d", i + 1), 32'(bus_b.vec_ready),
                  32'(tr_b[i].vec_ready));
            check($sformatf("cap2_resp_valid_c%0d", i + 1), 32'(bus_b.resp_valid),
                  32'(tr_b[i].resp_valid));
        end
        repeat (2) @(negedge clk);
        check("cap2_drained", 32'(exp_b.size()), 32'd0);
        check("cap2_resp_data", 32'(bus_b.resp_data), 32'd3);
        @(posedge clk);
        #1;

        // 256 forced mismatches saturate the counter, then one more must hold it.
        for (int i = 0; i < 256; i++) begin
            feed_q.push_back('{vec: 2'b01, exp: 2'b00, resp: 2'b11, mm: 1'b1});
        end
        feed_a();
        drain_a();
        check("sat_fail_count", 32'(bus_a.fail_count), 32'd255);
        feed_q.push_back('{vec: 2'b01, exp: 2'b00, resp: 2'b11, mm: 1'b1});
        feed_a();
        drain_a();
        check("sat_hold_fail_count", 32'(bus_a.fail_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
